// File: rtl/stream_splitter_if.sv
// Handshake bundle between one producer, the splitter and two consumers.
// The slave modport is the splitter's view. The master modport is the
// surrounding environment's view, which drives the producer and consumer sides.
interface stream_splitter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, b_data, b_valid, a_count, b_count
    );
endinterface

// File: rtl/stream_splitter.sv
// Registered 1-to-2 demultiplexer. Each input word goes to port A
// (in_sel=0) or port B (in_sel=1). Each port holds one word in a buffer
// with a valid/ready handshake. Each port also has a saturating counter of
// delivered words.
// Port index 0 is A and port index 1 is B throughout.
module stream_splitter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    stream_splitter_if.slave   bus
);
    localparam logic [0:0]       EMPTY   = 1'b0;
    localparam logic [0:0]       FULL    = 1'b1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       port_ready;
    logic [1:0]       port_valid;
    logic [1:0]       drain;
    logic [1:0]       load;
    logic [WIDTH-1:0] port_data  [2];
    logic [CNT_W-1:0] port_count [2];
    logic             ready;
    logic             accept;

    assign port_ready = {bus.b_ready, bus.a_ready};

    // A port can take a word when its buffer is empty or is being drained
    // this cycle. Only the port that in_sel selects decides, so a stall on
    // one port never blocks a word meant for the other port.
    assign ready  = bus.in_sel ? (~port_valid[1] | port_ready[1])
                               : (~port_valid[0] | port_ready[0]);
    assign accept = bus.in_valid & ready;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic [0:0]       state_reg;
            logic [0:0]       state_next;
            logic [WIDTH-1:0] data_reg;
            logic [CNT_W-1:0] count_reg;

            assign load[gi]  = accept & (bus.in_sel == 1'(gi));
            assign drain[gi] = (state_reg == FULL) & port_ready[gi];

            // Buffer occupancy: a load always leaves the buffer full, and a
            // drain empties it only when no new word replaces the old one.
            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    EMPTY:   state_next = load[gi] ? FULL : EMPTY;
                    FULL:    state_next = (drain[gi] && !load[gi]) ? EMPTY : FULL;
                    default: state_next = EMPTY;
                endcase
            end

            // State and data registers. Data changes only on a load, so a
            // stalled word stays stable.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= EMPTY;
                    data_reg  <= '0;
                end else begin
                    state_reg <= state_next;
                    if (load[gi]) begin
                        data_reg <= bus.in_data;
                    end
                end
            end

            // Delivered-word counter. It stops at all-ones and never wraps.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else if (drain[gi] && (count_reg != CNT_MAX)) begin
                    count_reg <= count_reg + 1'b1;
                end
            end

            assign port_valid[gi] = (state_reg == FULL);
            assign port_data[gi]  = data_reg;
            assign port_count[gi] = count_reg;
        end
    endgenerate

    assign bus.in_ready = ready;
    assign bus.a_valid  = port_valid[0];
    assign bus.a_data   = port_data[0];
    assign bus.a_count  = port_count[0];
    assign bus.b_valid  = port_valid[1];
    assign bus.b_data   = port_data[1];
    assign bus.b_count  = port_count[1];
endmodule
